// File: rtl/life_pkg.sv
// Shared state encoding, B3/S23 rule constants, neighbour offsets and index helpers
// for the Game-of-Life grid engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    localparam logic [3:0] BIRTH_N    = 4'd3;
    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;

    // Offsets in reading order: row above, same row (left/right), row below.
    localparam int NB_CNT = 8;
    localparam int NB_DX [NB_CNT] = '{-1,  0,  1, -1, 1, -1, 0, 1};
    localparam int NB_DY [NB_CNT] = '{-1, -1, -1,  0, 0,  1, 1, 1};

    function automatic int cell_idx(input int x, input int y, input int w);
        return y * w + x;
    endfunction

    function automatic int idx_x(input int idx, input int w);
        return idx % w;
    endfunction

    function automatic int idx_y(input int idx, input int w);
        return idx / w;
    endfunction

endpackage

// File: rtl/life_grid_engine_if.sv
// Host-side bundle of the life engine: step control, seed writes and the display read port.
interface life_grid_engine_if #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int GEN_W  = 16
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int PW = $clog2(GRID_W * GRID_H + 1);

    logic            frame_tick;
    logic            run;
    logic            step_now;
    logic            wr_en;
    logic [XW-1:0]   wr_x;
    logic [YW-1:0]   wr_y;
    logic            wr_data;
    logic            clear;
    logic [XW-1:0]   rd_x;
    logic [YW-1:0]   rd_y;
    logic            rd_alive;
    logic            busy;
    logic [GEN_W-1:0] generation;
    logic [PW-1:0]   population;

    modport master (
        output frame_tick, run, step_now, wr_en, wr_x, wr_y, wr_data, clear, rd_x, rd_y,
        input  rd_alive, busy, generation, population
    );

    modport slave (
        input  frame_tick, run, step_now, wr_en, wr_x, wr_y, wr_data, clear, rd_x, rd_y,
        output rd_alive, busy, generation, population
    );

endinterface

// File: rtl/life_rule.sv
// B3/S23 next-state evaluation for one cell from its eight neighbour bits.
module life_rule
    import life_pkg::*;
(
    input  logic [NB_CNT-1:0] nb,
    input  logic              centre,
    output logic              next_alive,
    output logic [3:0]        n
);

    always_comb begin
        n = '0;
        for (int k = 0; k < NB_CNT; k++) begin
            n = n + {3'b000, nb[k]};
        end
    end

    assign next_alive = centre ? (n == SURVIVE_LO || n == SURVIVE_HI) : (n == BIRTH_N);

endmodule

// File: rtl/life_grid_engine.sv
// Double-buffered Game-of-Life engine with a serial one-cell-per-clock scan.
// Define LIFE_WRAP_EN for toroidal edges; otherwise cells beyond the border count as dead.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int STEP_FRAMES = 60,
    parameter int GEN_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    life_grid_engine_if.slave  bus
);

    localparam int XW  = $clog2(GRID_W);
    localparam int YW  = $clog2(GRID_H);
    localparam int PW  = $clog2(GRID_W * GRID_H + 1);
    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;

    localparam logic [XW-1:0] X_LAST  = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(GRID_H - 1);
    localparam logic [XW:0]   W_LIM   = XW1'(GRID_W);
    localparam logic [YW:0]   H_LIM   = YW1'(GRID_H);
    localparam logic [7:0]    FC_LAST = 8'(STEP_FRAMES - 1);

    state_t                        state;
    logic [GRID_H-1:0][GRID_W-1:0] cur;
    logic [GRID_H-1:0][GRID_W-1:0] nxt;
    logic [XW-1:0]                 sx;
    logic [YW-1:0]                 sy;
    logic [PW-1:0]                 pop_sum;
    logic [7:0]                    frame_cnt;

    logic [NB_CNT-1:0] nb;
    logic              rule_next;
    logic [3:0]        unused_rule_n;
    logic              auto_hit;
    logic              start;
    logic              wr_ok;

    assign auto_hit = bus.frame_tick && bus.run && (frame_cnt == FC_LAST);
    assign start    = (state == IDLE) && (bus.step_now || auto_hit);
    assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_x} < W_LIM) && ({1'b0, bus.wr_y} < H_LIM);

    assign bus.rd_alive = (({1'b0, bus.rd_x} < W_LIM) && ({1'b0, bus.rd_y} < H_LIM)) ?
                          cur[bus.rd_y][bus.rd_x] : 1'b0;

    // Neighbours always come from cur, so the scan never sees its own partial results.
    always_comb begin
        int nx;
        int ny;
        nb = '0;
        for (int k = 0; k < NB_CNT; k++) begin
            nx = int'(sx) + NB_DX[k];
            ny = int'(sy) + NB_DY[k];
`ifdef LIFE_WRAP_EN
            if (nx < 0)            nx = nx + GRID_W;
            else if (nx >= GRID_W) nx = nx - GRID_W;
            if (ny < 0)            ny = ny + GRID_H;
            else if (ny >= GRID_H) ny = ny - GRID_H;
            nb[k] = cur[ny[YW-1:0]][nx[XW-1:0]];
`else
            if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H) begin
                nb[k] = cur[ny[YW-1:0]][nx[XW-1:0]];
            end
`endif
        end
    end

    life_rule u_rule (
        .nb         (nb),
        .centre     (cur[sy][sx]),
        .next_alive (rule_next),
        .n          (unused_rule_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cur            <= '0;
            nxt            <= '0;
            sx             <= '0;
            sy             <= '0;
            pop_sum        <= '0;
            frame_cnt      <= '0;
            bus.busy       <= 1'b0;
            bus.generation <= '0;
            bus.population <= '0;
        end else begin
            // Frame pacing runs regardless of state; a hit while busy is simply lost.
            if (bus.frame_tick && bus.run) begin
                frame_cnt <= (frame_cnt == FC_LAST) ? 8'd0 : frame_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        cur            <= '0;
                        bus.population <= '0;
                    end else if (wr_ok && (cur[bus.wr_y][bus.wr_x] != bus.wr_data)) begin
                        cur[bus.wr_y][bus.wr_x] <= bus.wr_data;
                        bus.population <= bus.wr_data ? bus.population + PW'(1)
                                                      : bus.population - PW'(1);
                    end
                    if (start) begin
                        state    <= SCAN;
                        sx       <= '0;
                        sy       <= '0;
                        pop_sum  <= '0;
                        bus.busy <= 1'b1;
                    end
                end

                SCAN: begin
                    nxt[sy][sx] <= rule_next;
                    pop_sum     <= pop_sum + PW'(rule_next);
                    if (sx == X_LAST) begin
                        sx <= '0;
                        if (sy == Y_LAST) state <= COMMIT;
                        else              sy    <= sy + YW'(1);
                    end else begin
                        sx <= sx + XW'(1);
                    end
                end

                COMMIT: begin
                    cur            <= nxt;
                    bus.population <= pop_sum;
                    bus.generation <= bus.generation + GEN_W'(1);
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// Randomised scoreboard bench for life_grid_engine against an array-based Life model.
module tb_life_grid_engine;

    localparam int W        = 16;
    localparam int H        = 16;
    localparam int SF       = 60;
    localparam int GW       = 16;
    localparam int NC       = W * H;
    localparam int XW       = $clog2(W);
    localparam int YW       = $clog2(H);
    localparam int BUSY_CYC = NC + 1;

    logic clk = 1'b0;
    logic reset;
    always #500 clk = ~clk;

    life_grid_engine_if #(.GRID_W(W), .GRID_H(H), .GEN_W(GW)) bus ();

    life_grid_engine #(.GRID_W(W), .GRID_H(H), .STEP_FRAMES(SF), .GEN_W(GW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit [NC-1:0] cells;
        int          pop;
        int          gen;
    } exp_t;

    exp_t exp_q[$];
    bit   model [H][W];
    int   model_gen = 0;
    int   run_cnt   = 0;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_grid(input string name, input bit [NC-1:0] got, input bit [NC-1:0] want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int alive_at(input int x, input int y);
`ifdef LIFE_WRAP_EN
        x = (x + W) % W;
        y = (y + H) % H;
`else
        if (x < 0 || x >= W || y < 0 || y >= H) return 0;
`endif
        return int'(model[y][x]);
    endfunction

    function automatic bit [NC-1:0] model_pack();
        bit [NC-1:0] p;
        p = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                p[y*W + x] = model[y][x];
        return p;
    endfunction

    function automatic int model_pop();
        int c;
        c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                c += int'(model[y][x]);
        return c;
    endfunction

    function automatic void model_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                model[y][x] = 1'b0;
    endfunction

    function automatic void model_advance();
        bit   nx [H][W];
        int   n;
        exp_t e;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0) n += alive_at(x + dx, y + dy);
                nx[y][x] = (n == 3) || (model[y][x] && n == 2);
            end
        end
        model     = nx;
        model_gen = (model_gen + 1) % (1 << GW);
        e.cells   = model_pack();
        e.pop     = model_pop();
        e.gen     = model_gen;
        exp_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    task automatic sweep(output bit [NC-1:0] got);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                bus.rd_x = XW'(x);
                bus.rd_y = YW'(y);
                #1;
                got[y*W + x] = bus.rd_alive;
            end
        end
    endtask

    initial begin : monitor
        bit          was_busy;
        bit          rst_seen;
        int          blen;
        bit [NC-1:0] got;
        exp_t        e;
        was_busy = 1'b0;
        rst_seen = 1'b0;
        blen     = 0;
        bus.rd_x = '0;
        bus.rd_y = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rst_seen = 1'b1;
                was_busy = 1'b0;
                blen     = 0;
            end else begin
                if (rst_seen) begin
                    rst_seen = 1'b0;
                    check("rst_busy", bus.busy, 0);
                    check("rst_gen", bus.generation, 0);
                    check("rst_pop", bus.population, 0);
                    sweep(got);
                    check_grid("rst_grid", got, '0);
                end
                if (bus.busy) begin
                    was_busy = 1'b1;
                    blen++;
                end else if (was_busy) begin
                    was_busy = 1'b0;
                    check("busy_len", blen, BUSY_CYC);
                    blen = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: got generation %0d expected no step",
                                 bus.generation);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_gen", bus.generation, e.gen);
                        check("commit_pop", bus.population, e.pop);
                        sweep(got);
                        check_grid("commit_grid", got, e.cells);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input bit d);
        bus.wr_en   = 1'b1;
        bus.wr_x    = XW'(x);
        bus.wr_y    = YW'(y);
        bus.wr_data = d;
        cyc();
        bus.wr_en   = 1'b0;
        model[y][x] = d;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        model_clear();
        check("clear_pop", bus.population, 0);
        check("clear_gen", bus.generation, model_gen);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (bus.busy && t < 2 * BUSY_CYC) begin
            cyc();
            t++;
        end
        if (t >= 2 * BUSY_CYC) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still high after %0d cycles, required low", name, t);
        end
        cyc();
    endtask

    task automatic step(input string name);
        bus.step_now = 1'b1;
        model_advance();
        cyc();
        bus.step_now = 1'b0;
        check({name, "_busy"}, bus.busy, 1);
        wait_done(name);
    endtask

    task automatic ftick(input bit also_step, input string name);
        bit hit;
        hit = 1'b0;
        if (bus.run) begin
            run_cnt++;
            if (run_cnt == SF) begin
                run_cnt = 0;
                hit     = 1'b1;
            end
        end
        if (hit || also_step) model_advance();
        bus.frame_tick = 1'b1;
        bus.step_now   = also_step;
        cyc();
        bus.frame_tick = 1'b0;
        bus.step_now   = 1'b0;
        if (hit || also_step)                check({name, "_start"}, bus.busy, 1);
        else if (bus.run && run_cnt == SF-1) check({name, "_early"}, bus.busy, 0);
        repeat (7) cyc();
    endtask

    task automatic random_seed();
        do_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if ($urandom_range(0, 99) < 35) wr(x, y, 1'b1);
        for (int i = 0; i < 40; i++)
            wr($urandom_range(0, W-1), $urandom_range(0, H-1), 1'($urandom_range(0, 1)));
        check("seed_pop", bus.population, model_pop());
    endtask

    initial begin : stim
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.run        = 1'b0;
        bus.step_now   = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_x       = '0;
        bus.wr_y       = '0;
        bus.wr_data    = 1'b0;
        bus.clear      = 1'b0;
        model_clear();
        repeat (3) cyc();
        reset = 1'b0;
        repeat (2) cyc();

        // Blinker: vertical -> horizontal -> vertical.
        do_clear();
        wr(7, 6, 1'b1); wr(7, 7, 1'b1); wr(7, 8, 1'b1);
        check("blinker_pop", bus.population, 3);
        step("blinker1");
        step("blinker2");

        // Block still life over five generations.
        do_clear();
        wr(3, 3, 1'b1); wr(4, 3, 1'b1); wr(3, 4, 1'b1); wr(4, 4, 1'b1);
        wr(4, 4, 1'b1);
        check("block_pop", bus.population, 4);
        for (int i = 0; i < 5; i++) step("block");

        // Corners: edge handling differs between wrap and no-wrap builds.
        do_clear();
        wr(0, 0, 1'b1); wr(W-1, 0, 1'b1); wr(0, H-1, 1'b1);
        wr(5, 5, 1'b0);
        check("corner_pop", bus.population, 3);
        step("corner");

        // Random soups.
        for (int s = 0; s < 3; s++) begin
            random_seed();
            for (int i = 0; i < 3; i++) step("rand");
        end

        // Write and start in the same cycle: the scan must see the written cell.
        do_clear();
        wr(4, 5, 1'b1); wr(6, 5, 1'b1);
        bus.wr_en = 1'b1; bus.wr_x = XW'(5); bus.wr_y = YW'(5); bus.wr_data = 1'b1;
        bus.step_now = 1'b1;
        model[5][5] = 1'b1;
        model_advance();
        cyc();
        bus.wr_en = 1'b0; bus.step_now = 1'b0;
        check("wrstart_busy", bus.busy, 1);
        wait_done("wrstart");

        // Clear wins over a same-cycle write.
        bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_x = XW'(2); bus.wr_y = YW'(2); bus.wr_data = 1'b1;
        cyc();
        bus.clear = 1'b0; bus.wr_en = 1'b0;
        model_clear();
        check("clearwr_pop", bus.population, 0);
        step("clearwr");

        // Writes, clears and starts while busy are all dropped.
        random_seed();
        bus.step_now = 1'b1;
        model_advance();
        cyc();
        bus.step_now = 1'b0;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(3, 9)) cyc();
            bus.wr_en    = 1'b1;
            bus.wr_x     = XW'($urandom_range(0, W-1));
            bus.wr_y     = YW'($urandom_range(0, H-1));
            bus.wr_data  = 1'b1;
            bus.step_now = 1'($urandom_range(0, 1));
            bus.clear    = (i == 10);
            cyc();
            bus.wr_en = 1'b0; bus.step_now = 1'b0; bus.clear = 1'b0;
        end
        check("drop_busy", bus.busy, 1);
        wait_done("drop");
        check("drop_pop", bus.population, model_pop());

        // Frame-paced auto stepping, with a hold period and a coincident step_now.
        random_seed();
        bus.run = 1'b1;
        for (int i = 1; i <= 2*SF; i++) ftick(i == 2*SF, "auto");
        bus.run = 1'b0;
        for (int i = 0; i < SF/2; i++) ftick(1'b0, "hold");
        bus.run = 1'b1;
        for (int i = 0; i < SF; i++) ftick(1'b0, "resume");
        bus.run = 1'b0;
        wait_done("auto_end");

        // Reset in the middle of a scan.
        random_seed();
        bus.step_now = 1'b1;
        model_advance();
        cyc();
        bus.step_now = 1'b0;
        repeat (100) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        model_clear();
        model_gen = 0;
        run_cnt   = 0;
        repeat (3) cyc();
        step("post_rst");

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
